// File: rtl/q3_fsm_steer_driver.sv
// q3_fsm_steer_driver
// Stimulus-side partner for the 3-bit x/z Moore FSM (states 000..100, z=1 in
// 011/100). The block takes a target state over a valid/ready handshake. It keeps
// a shadow copy of the FSM state and drives x one bit per clock, steering the
// FSM along the shortest path to the target. It reports done with a step count,
// or err when the target cannot be reached.
//
// Optional feature: define Z_CHECK_EN to compare z_in against the z value
// predicted from the shadow state. Any difference sets the sticky mismatch flag.
// When the macro is undefined, mismatch is tied to 0 and z_in is ignored.
//
// Ports
//   clk        in   clock, rising edge
//   areset_n   in   asynchronous active-low reset
//   tgt_valid  in   target request valid
//   tgt_state  in   requested FSM state [2:0]
//   tgt_ready  out  request can be accepted (IDLE only)
//   x          out  FSM input, decoded from registered state only
//   z_in       in   z observed from the FSM
//   shadow     out  modelled FSM state [2:0]
//   done       out  one-cycle pulse: shadow reached target
//   err        out  one-cycle pulse: request rejected
//   steps      out  x cycles used by the last request [CNT_W-1:0]
//   mismatch   out  sticky z disagreement flag
//
// State | meaning
// IDLE  | waiting for a request; x holds the FSM still
// STEER | driving x along the route to the target
// DONE  | done pulse cycle; steps holds the count

module q3_fsm_steer_driver #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             tgt_valid,
    input  logic [2:0]       tgt_state,
    output logic             tgt_ready,
    output logic             x,
    input  logic             z_in,
    output logic [2:0]       shadow,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] steps,
    output logic             mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEER = 2'd1,
        DONE  = 2'd2
    } ctl_t;

    ctl_t       ctl;
    logic [2:0] tgt;
    logic [2:0] shadow_nxt;

    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic xi);
        logic [2:0] n;
        n = 3'b000;
        case (s)
            3'b000:  n = xi ? 3'b001 : 3'b000;
            3'b001:  n = xi ? 3'b100 : 3'b001;
            3'b010:  n = xi ? 3'b001 : 3'b010;
            3'b011:  n = xi ? 3'b010 : 3'b001;
            3'b100:  n = xi ? 3'b100 : 3'b011;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    // Outside STEER, x=1 only in 100, because that is the only state whose
    // self-loop needs x=1. In STEER, 100 and 011 (unless the target is 010)
    // are the only states that advance toward their targets with x=0.
    always_comb begin
        x = (shadow == 3'b100);
        if (ctl == STEER)
            x = !((shadow == 3'b100) || ((shadow == 3'b011) && (tgt != 3'b010)));
    end

    assign shadow_nxt = fsm_next(shadow, x);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            ctl       <= IDLE;
            shadow    <= 3'b000;
            tgt       <= 3'b000;
            tgt_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            steps     <= '0;
        end else begin
            shadow <= shadow_nxt;
            done   <= 1'b0;
            err    <= 1'b0;
            case (ctl)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        // 000 has no entry edge, so it can only be "reached" by
                        // already being there.
                        if ((tgt_state > 3'b100) ||
                            ((tgt_state == 3'b000) && (shadow != 3'b000))) begin
                            err <= 1'b1;
                        end else if (tgt_state == shadow) begin
                            tgt       <= tgt_state;
                            steps     <= '0;
                            done      <= 1'b1;
                            tgt_ready <= 1'b0;
                            ctl       <= DONE;
                        end else begin
                            tgt       <= tgt_state;
                            steps     <= '0;
                            tgt_ready <= 1'b0;
                            ctl       <= STEER;
                        end
                    end
                end
                STEER: begin
                    if (steps != {CNT_W{1'b1}})
                        steps <= steps + 1'b1;
                    if (shadow_nxt == tgt) begin
                        done <= 1'b1;
                        ctl  <= DONE;
                    end
                end
                DONE: begin
                    tgt_ready <= 1'b1;
                    ctl       <= IDLE;
                end
                default: begin
                    tgt_ready <= 1'b1;
                    ctl       <= IDLE;
                end
            endcase
        end
    end

`ifdef Z_CHECK_EN
    logic z_model;
    assign z_model = (shadow == 3'b011) || (shadow == 3'b100);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            mismatch <= 1'b0;
        else if (z_in != z_model)
            mismatch <= 1'b1;
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_q3_fsm_steer_driver.sv
module tb_q3_fsm_steer_driver;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [2:0] tgt_state = 3'b000;
    logic       tgt_ready;
    logic       x;
    logic       z_in;
    logic [2:0] shadow;
    logic       done;
    logic       err;
    logic [2:0] steps;
    logic       mismatch;

    logic [2:0] fsm_q;
    logic       force_z0 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    q3_fsm_steer_driver #(.CNT_W(3)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .tgt_valid (tgt_valid),
        .tgt_state (tgt_state),
        .tgt_ready (tgt_ready),
        .x         (x),
        .z_in      (z_in),
        .shadow    (shadow),
        .done      (done),
        .err       (err),
        .steps     (steps),
        .mismatch  (mismatch)
    );

    // The real FSM being steered. Its z output feeds z_in.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) fsm_q <= 3'b000;
        else begin
            case (fsm_q)
                3'b000:  fsm_q <= x ? 3'b001 : 3'b000;
                3'b001:  fsm_q <= x ? 3'b100 : 3'b001;
                3'b010:  fsm_q <= x ? 3'b001 : 3'b010;
                3'b011:  fsm_q <= x ? 3'b010 : 3'b001;
                3'b100:  fsm_q <= x ? 3'b100 : 3'b011;
                default: fsm_q <= 3'b000;
            endcase
        end
    end

    assign z_in = force_z0 ? 1'b0 : ((fsm_q == 3'b011) || (fsm_q == 3'b100));

`ifdef Z_CHECK_EN
    localparam logic MM_EXP = 1'b1;
`else
    localparam logic MM_EXP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every output that a step can change, all in one call.
    task automatic chk_all(input string tag, input logic [2:0] sh, input logic xx,
                           input logic rdy, input logic dn, input logic er,
                           input logic [2:0] st);
        chk({tag, ".shadow"}, 8'(shadow), 8'(sh));
        chk({tag, ".x"}, 8'(x), 8'(xx));
        chk({tag, ".ready"}, 8'(tgt_ready), 8'(rdy));
        chk({tag, ".done"}, 8'(done), 8'(dn));
        chk({tag, ".err"}, 8'(err), 8'(er));
        chk({tag, ".steps"}, 8'(steps), 8'(st));
    endtask

    task automatic request(input logic [2:0] t);
        tgt_valid = 1'b1;
        tgt_state = t;
        tick();
        tgt_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk_all("rst", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("rst.mismatch", 8'(mismatch), 8'd0);
        areset_n = 1'b1;
        tick();

        // 1: 000 -> 100 via 001, two steps
        request(3'b100);
        chk_all("t1.acc", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        chk_all("t1.s1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        chk_all("t1.dn", 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        tick();
        chk_all("t1.idle", 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);

        // 2: 100 -> 010 via 011. A request held during STEER must be ignored.
        tgt_valid = 1'b1;
        tgt_state = 3'b010;
        tick();
        tgt_state = 3'b000;
        chk_all("t2.acc", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        chk_all("t2.s1", 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        tgt_valid = 1'b0;
        chk_all("t2.dn", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        tick();
        chk_all("t2.idle", 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

        // 3: target equals shadow
        request(3'b010);
        chk_all("t3.dn", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        chk_all("t3.idle", 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        // 010 -> 001 in one step, to set up the rejection cases
        request(3'b001);
        tick();
        chk_all("t4.pre", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        tick();

        // 4: rejected requests
        request(3'b000);
        chk_all("t4.err0", 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        request(3'b110);
        chk_all("t4.err6", 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
        tick();
        chk_all("t4.clr", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

        // 5: 001 -> 011 via 100, then a z mismatch while the shadow is 011
        request(3'b011);
        tick();
        chk_all("t5.s1", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        chk_all("t5.dn", 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("t5.mm_pre", 8'(mismatch), 8'd0);
        force_z0 = 1'b1;
        tick();
        force_z0 = 1'b0;
        chk("t5.mm", 8'(mismatch), 8'(MM_EXP));
        chk("t5.idle_sh", 8'(shadow), 8'b001);
        tick();
        chk("t5.mm_sticky", 8'(mismatch), 8'(MM_EXP));

        // 001 -> 010 in three steps, to set up the reset case
        request(3'b010);
        tick(); tick();
        chk("t6.pre_sh", 8'(shadow), 8'b011);
        tick();
        chk_all("t6.pre", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
        tick();

        // 6: reset during step 2 of 010 -> 100
        request(3'b100);
        tick();
        chk_all("t6.s1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        #2 areset_n = 1'b0;
        #1;
        chk_all("t6.rst", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("t6.mm", 8'(mismatch), 8'd0);
        tick();
        areset_n = 1'b1;
        tick();
        chk_all("t6.after", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("t6.sync", 8'(fsm_q), 8'(shadow));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: run did not end, got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
